// File: rtl/ysyx_25060170_pkg.sv
// Shared types and constants for the NPC write-back unit.
package ysyx_25060170_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   // One EXU result waiting to be committed into the register file.
   typedef struct packed {
      logic [XLEN-1:0]   result;
      logic [REG_AW-1:0] rd;
      logic              wen;
      logic              trap;
   } wb_entry_t;

   localparam wb_entry_t ENTRY_ZERO = '{
      result: {XLEN{1'b0}},
      rd:     {REG_AW{1'b0}},
      wen:    1'b0,
      trap:   1'b0
   };

endpackage

// File: rtl/ysyx_25060170_wb_fifo.sv
// In-order buffer of pending write-back entries. Besides the head it
// exposes every slot in age order (index 0 = oldest) with a valid mask
// so the owner can forward uncommitted results.
module ysyx_25060170_wb_fifo
   import ysyx_25060170_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  wb_entry_t             push_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output wb_entry_t             head,
   output wb_entry_t [DEPTH-1:0] entries,
   output logic      [DEPTH-1:0] valid_mask
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t       mem_r [DEPTH];
   logic [AW-1:0]   rd_ptr_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [AW:0]     count_r;
   logic [AW:0]     count_next_s;
   logic [AW-1:0]   slot_s;

   assign full  = (count_r == (AW+1)'(DEPTH));
   assign empty = (count_r == {(AW+1){1'b0}});
   assign head  = mem_r[rd_ptr_r];

   // Occupancy bookkeeping for simultaneous push/pop.
   always_comb begin
      count_next_s = count_r;
      case ({push, pop})
         2'b10:   count_next_s = count_r + (AW+1)'(1);
         2'b01:   count_next_s = count_r - (AW+1)'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Age-ordered view of the storage for the forwarding logic.
   always_comb begin
      slot_s = rd_ptr_r;
      for (int i = 0; i < DEPTH; i++) begin
         slot_s        = rd_ptr_r + AW'(i);
         entries[i]    = mem_r[slot_s];
         valid_mask[i] = ((AW+1)'(i) < count_r);
      end
   end

   // Storage and pointers; a flush drops everything, including a same-edge push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= ENTRY_ZERO;
         end
      end else if (flush) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_next_s;
      end
   end

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: buffers EXU results, commits them in order into the
// 32x32 register file, forwards pending results to the read ports and
// halts the core after an ebreak commits.
module ysyx_25060170_wbu #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid_i,
   output logic                                  in_ready_o,
   input  logic [XLEN-1:0]                       in_result_i,
   input  logic [ysyx_25060170_pkg::REG_AW-1:0]  in_rd_i,
   input  logic                                  in_wen_i,
   input  logic                                  in_trap_i,
   input  logic                                  stall_i,
   input  logic [ysyx_25060170_pkg::REG_AW-1:0]  rs1_addr_i,
   input  logic [ysyx_25060170_pkg::REG_AW-1:0]  rs2_addr_i,
   output logic [XLEN-1:0]                       rs1_data_o,
   output logic [XLEN-1:0]                       rs2_data_o,
   output logic                                  retire_o,
   output logic                                  trap_o,
   output logic                                  halted_o
);

   import ysyx_25060170_pkg::*;

   wb_entry_t             push_data_s;
   wb_entry_t             head_s;
   wb_entry_t [DEPTH-1:0] entries_s;
   logic      [DEPTH-1:0] valid_mask_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  commit_wen_s;
   logic                  halted_r;
   logic [XLEN-1:0]       regs_r [NUM_REGS];

   // Read one port: x0 is hard zero, the youngest pending writer wins,
   // otherwise the architectural register.
   function automatic logic [XLEN-1:0] fwd_read(
      input logic [REG_AW-1:0]   addr,
      input logic [XLEN-1:0]     reg_val,
      input wb_entry_t [DEPTH-1:0] ents,
      input logic [DEPTH-1:0]    mask
   );
      logic [XLEN-1:0] data;
      data = reg_val;
      for (int i = 0; i < DEPTH; i++) begin
         if (mask[i] && ents[i].wen && (ents[i].rd == addr)) begin
            data = ents[i].result;
         end else begin
            data = data;
         end
      end
      if (addr == {REG_AW{1'b0}}) begin
         data = {XLEN{1'b0}};
      end else begin
         data = data;
      end
      return data;
   endfunction

   assign push_data_s = '{result: in_result_i, rd: in_rd_i, wen: in_wen_i, trap: in_trap_i};
   assign halted_o    = halted_r;

   // Handshake and commit control; ready depends only on stored state.
   always_comb begin
      in_ready_o   = !full_s && !halted_r;
      push_s       = in_valid_i && in_ready_o;
      pop_s        = !empty_s && !stall_i && !halted_r;
      retire_o     = pop_s;
      trap_o       = pop_s && head_s.trap;
      commit_wen_s = pop_s && head_s.wen && (head_s.rd != {REG_AW{1'b0}});
   end

   // Combinational read ports with forwarding from uncommitted entries.
   always_comb begin
      rs1_data_o = fwd_read(rs1_addr_i, regs_r[rs1_addr_i], entries_s, valid_mask_s);
      rs2_data_o = fwd_read(rs2_addr_i, regs_r[rs2_addr_i], entries_s, valid_mask_s);
   end

   // Architectural register file; x0 is never written.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (commit_wen_s) begin
         regs_r[head_s.rd] <= head_s.result;
      end
   end

   // Sticky halt, set on the edge that commits a trap entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halted_r <= 1'b0;
      end else if (trap_o) begin
         halted_r <= 1'b1;
      end
   end

   ysyx_25060170_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s),
      .push_data  (push_data_s),
      .pop        (pop_s),
      .flush      (trap_o),
      .full       (full_s),
      .empty      (empty_s),
      .head       (head_s),
      .entries    (entries_s),
      .valid_mask (valid_mask_s)
   );

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Directed, table-driven bench for the write-back unit.
module tb_ysyx_25060170_wbu;

   typedef struct {
      logic        valid;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        wen;
      logic        trap;
      logic        stall;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        e_ready;
      logic        e_retire;
      logic        e_trap;
      logic        e_halted;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        in_trap;
   logic        stall;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        retire;
   logic        trap;
   logic        halted;

   int n_checks;
   int n_fail;
   vec_t vecs [18];

   ysyx_25060170_wbu dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_result_i (in_result),
      .in_rd_i     (in_rd),
      .in_wen_i    (in_wen),
      .in_trap_i   (in_trap),
      .stall_i     (stall),
      .rs1_addr_i  (rs1_addr),
      .rs2_addr_i  (rs2_addr),
      .rs1_data_o  (rs1_data),
      .rs2_data_o  (rs2_data),
      .retire_o    (retire),
      .trap_o      (trap),
      .halted_o    (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(
      input logic v, input logic [31:0] res, input logic [4:0] rd,
      input logic wen, input logic tr, input logic st,
      input logic [4:0] a1, input logic [4:0] a2,
      input logic erdy, input logic eret, input logic etrp, input logic ehlt,
      input logic [31:0] ed1, input logic [31:0] ed2
   );
      vec_t x;
      x.valid = v;     x.result = res;   x.rd = rd;       x.wen = wen;
      x.trap = tr;     x.stall = st;     x.rs1 = a1;      x.rs2 = a2;
      x.e_ready = erdy; x.e_retire = eret; x.e_trap = etrp; x.e_halted = ehlt;
      x.e_rs1 = ed1;   x.e_rs2 = ed2;
      return x;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      in_valid  = x.valid;
      in_result = x.result;
      in_rd     = x.rd;
      in_wen    = x.wen;
      in_trap   = x.trap;
      stall     = x.stall;
      rs1_addr  = x.rs1;
      rs2_addr  = x.rs2;
   endtask

   task automatic compare(input vec_t x, input int row);
      chk("in_ready", row, {31'd0, in_ready}, {31'd0, x.e_ready});
      chk("retire",   row, {31'd0, retire},   {31'd0, x.e_retire});
      chk("trap",     row, {31'd0, trap},     {31'd0, x.e_trap});
      chk("halted",   row, {31'd0, halted},   {31'd0, x.e_halted});
      chk("rs1_data", row, rs1_data, x.e_rs1);
      chk("rs2_data", row, rs2_data, x.e_rs2);
   endtask

   // Drive a row in the low phase and check before the next rising edge.
   task automatic run_vec(input vec_t x, input int row);
      @(negedge clk);
      drive(x);
      #1;
      compare(x, row);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(mk(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      drive(mk(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));

      //             v  result          rd    wen   trap  stall rs1   rs2    rdy   ret   trp   hlt   rs1_data        rs2_data
      vecs[0]  = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
      vecs[1]  = mk(1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
      vecs[2]  = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0);
      vecs[3]  = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h0);
      vecs[4]  = mk(1'b1, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
      vecs[5]  = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0);
      vecs[6]  = mk(1'b1, 32'hA,        5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
      vecs[7]  = mk(1'b1, 32'hB,        5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'hA,        32'h0);
      vecs[8]  = mk(1'b1, 32'hC,        5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 32'hB,        32'h12345678);
      vecs[9]  = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'hB,        32'h0);
      vecs[10] = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'hB,        32'h0);
      vecs[11] = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'hB,        32'h0);
      vecs[12] = mk(1'b1, 32'h0,        5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'hB);
      vecs[13] = mk(1'b1, 32'h55,       5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
      vecs[14] = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h55,       32'h0);
      vecs[15] = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h55,       32'h0);
      vecs[16] = mk(1'b1, 32'h77,       5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0);
      vecs[17] = mk(1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hB);

      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int r = 0; r < 18; r++) begin
         run_vec(vecs[r], r);
      end

      // Reset clears the halt and the register file.
      do_reset();
      run_vec(mk(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd5,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), 100);

      // Eight back-to-back pushes with no stall: pointers wrap repeatedly.
      for (int i = 0; i < 8; i++) begin
         run_vec(mk(1'b1, 32'h100 + 32'(i), 5'(10 + i), 1'b1, 1'b0, 1'b0,
                    5'(10 + i), (i > 0) ? 5'(9 + i) : 5'd0,
                    1'b1, (i > 0) ? 1'b1 : 1'b0, 1'b0, 1'b0,
                    32'h0, (i > 0) ? 32'h100 + 32'(i - 1) : 32'h0), 200 + i);
      end
      run_vec(mk(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0,
                 1'b1, 1'b1, 1'b0, 1'b0, 32'h107, 32'h0), 208);
      for (int k = 0; k < 8; k++) begin
         run_vec(mk(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'(10 + k), 5'(17 - k),
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(k), 32'h107 - 32'(k)), 210 + k);
      end

      // Reset asserted mid-stream takes effect without waiting for a clock.
      for (int i = 0; i < 2; i++) begin
         run_vec(mk(1'b1, 32'h200 + 32'(i), 5'(20 + i), 1'b1, 1'b0, 1'b0,
                    5'd0, 5'd0, 1'b1, (i > 0) ? 1'b1 : 1'b0, 1'b0, 1'b0,
                    32'h0, 32'h0), 300 + i);
      end
      @(negedge clk);
      drive(mk(1'b1, 32'h202, 5'd22, 1'b1, 1'b0, 1'b0, 5'd21, 5'd10,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      #2;
      rst = 1'b0;
      #1;
      compare(mk(1'b1, 32'h202, 5'd22, 1'b1, 1'b0, 1'b0, 5'd21, 5'd10,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), 302);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         run_vec(mk(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 5'(10 + k), 5'(20 + (k % 3)),
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0), 310 + k);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
